// File: rtl/frame_mem_arbiter_if.sv
// Bundle of display-read, game-write and RAM-side signals around the frame memory arbiter.
interface frame_mem_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) ();
   logic              vga_re;
   logic [ADDR_W-1:0] vga_addr;
   logic [DATA_W-1:0] vga_data;
   logic              vga_valid;
   logic              vga_miss;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Requesters and RAM side: drive requests and read data, observe results.
   modport master (
      output vga_re, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
      input  vga_data, vga_valid, vga_miss, wr_ack,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   // Arbiter side.
   modport slave (
      input  vga_re, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
      output vga_data, vga_valid, vga_miss, wr_ack,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Single-port frame memory arbiter: display reads take priority, game-logic
// writes are forced through after MAX_WAIT cycles of starvation.
module frame_mem_arbiter #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 15
) (
   input logic           clk,
   input logic           reset,
   frame_mem_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [1:0]        state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic              rd_pend_q, rd_pend_d;
   logic              vga_valid_q, vga_valid_d;
   logic [DATA_W-1:0] vga_data_q, vga_data_d;
   logic              vga_miss_q, vga_miss_d;
   logic              wr_ack_q, wr_ack_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              grant_wr;

   // Next-state arbitration, starvation counter and registered memory command.
   always_comb begin
      // A request seen on its own ack edge is the same request, not a new one.
      grant_wr = bus.wr_req && !wr_ack_q && (!bus.vga_re || (wait_q == MAX_WAIT_C));

      state_d = S_IDLE;
      if (grant_wr)        state_d = S_WR;
      else if (bus.vga_re) state_d = S_RD;

      wait_d = wait_q;
      if (!bus.wr_req || grant_wr)  wait_d = 8'd0;
      else if (!wr_ack_q)           wait_d = (wait_q >= MAX_WAIT_C) ? wait_q : wait_q + 8'd1;

      mem_en_d    = (state_d != S_IDLE);
      mem_we_d    = (state_d == S_WR);
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (state_d == S_WR) begin
         mem_addr_d  = bus.wr_addr;
         mem_wdata_d = bus.wr_data;
      end else if (state_d == S_RD) begin
         mem_addr_d  = bus.vga_addr;
      end

      wr_ack_d   = grant_wr;
      vga_miss_d = grant_wr && bus.vga_re;

      // RD cycle -> RAM samples at the following edge -> capture one edge later.
      rd_pend_d   = (state_q == S_RD);
      vga_valid_d = rd_pend_q;
      vga_data_d  = rd_pend_q ? bus.mem_rdata : vga_data_q;
   end

   // State and output registers; reset discards any reads in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wait_q      <= 8'd0;
         rd_pend_q   <= 1'b0;
         vga_valid_q <= 1'b0;
         vga_data_q  <= '0;
         vga_miss_q  <= 1'b0;
         wr_ack_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         rd_pend_q   <= rd_pend_d;
         vga_valid_q <= vga_valid_d;
         vga_data_q  <= vga_data_d;
         vga_miss_q  <= vga_miss_d;
         wr_ack_q    <= wr_ack_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.vga_data  = vga_data_q;
   assign bus.vga_valid = vga_valid_q;
   assign bus.vga_miss  = vga_miss_q;
   assign bus.wr_ack    = wr_ack_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: per-cycle vector table plus read-data scoreboard.
module tb_frame_mem_arbiter;
   localparam int AW = 11;
   localparam int DW = 8;
   localparam int MW = 15;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   frame_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   frame_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 11'h123) return 8'h05;
      return a[7:0] ^ {a[10:8], 5'b0} ^ 8'h5A;
   endfunction

   // Synchronous single-port RAM model.
   bit [DW-1:0] ram   [0:(1<<AW)-1];
   bit          ram_w [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            ram[bus.mem_addr]   <= bus.mem_wdata;
            ram_w[bus.mem_addr] <= 1'b1;
         end else begin
            bus.mem_rdata <= ram_w[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
         end
      end
   end

   typedef struct {
      logic          re;
      logic [AW-1:0] ra;
      logic          wq;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          e_en, e_we, e_ack, e_miss;
   } vec_t;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } sb_t;

   vec_t          vecs[$];
   sb_t           sbq[$];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   logic [DW-1:0] last_data;
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   function automatic vec_t mk(input logic re, input logic [AW-1:0] ra, input logic wq,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic en, input logic we, input logic ack, input logic miss);
      vec_t v;
      v.re = re; v.ra = ra; v.wq = wq; v.wa = wa; v.wd = wd;
      v.e_en = en; v.e_we = we; v.e_ack = ack; v.e_miss = miss;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic sb_check();
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         chk("vga_valid", 32'(bus.vga_valid), 32'd1);
         chk("vga_data", 32'(bus.vga_data), 32'(sbq[0].data));
         last_data = sbq[0].data;
         void'(sbq.pop_front());
      end else begin
         chk("vga_valid_idle", 32'(bus.vga_valid), 32'd0);
         chk("vga_data_hold", 32'(bus.vga_data), 32'(last_data));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_vga_valid"}, 32'(bus.vga_valid), 32'd0);
      chk({tag, "_vga_data"},  32'(bus.vga_data),  32'd0);
      chk({tag, "_vga_miss"},  32'(bus.vga_miss),  32'd0);
      chk({tag, "_wr_ack"},    32'(bus.wr_ack),    32'd0);
      chk({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
   endtask

   // One clock: drive inputs, let the edge sample them, check on the falling edge.
   task automatic apply(input vec_t v);
      bus.vga_re   = v.re;
      bus.vga_addr = v.ra;
      bus.wr_req   = v.wq;
      bus.wr_addr  = v.wa;
      bus.wr_data  = v.wd;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("mem_en",   32'(bus.mem_en),   32'(v.e_en));
      chk("mem_we",   32'(bus.mem_we),   32'(v.e_we));
      chk("wr_ack",   32'(bus.wr_ack),   32'(v.e_ack));
      chk("vga_miss", 32'(bus.vga_miss), 32'(v.e_miss));
      if (v.e_en && v.e_we) begin
         chk("mem_addr_wr", 32'(bus.mem_addr),  32'(v.wa));
         chk("mem_wdata",   32'(bus.mem_wdata), 32'(v.wd));
         shadow[v.wa] = v.wd;
      end else if (v.e_en) begin
         chk("mem_addr_rd", 32'(bus.mem_addr), 32'(v.ra));
      end
      sb_check();
      if (v.e_en && !v.e_we) sbq.push_back('{due: cyc + 2, data: shadow[v.ra]});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(11'(i));
      last_data = '0;
      bus.vga_re = 1'b0; bus.vga_addr = '0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

      // Vector table.
      vecs.push_back(mk(1'b1, 11'h123, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b1, 11'h010, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 11'h010, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b1, 11'(11'h100 + i), 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(1'b0, '0, 1'b1, 11'h020, 8'h11, (i % 2 == 0), (i % 2 == 0), (i % 2 == 0), 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 11'h020, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b1, 11'(11'h030 + i), 1'b1, 11'h040, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b1, 11'h040, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 11'h040, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, '0, 1'b1, 11'h7FF, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 11'h7FF, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 11'h4B0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Contention: reads starve the write until the counter hits the limit.
      for (int i = 0; i < MW; i++)
         apply(mk(1'b1, 11'(11'h200 + i), 1'b1, 11'h060, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(mk(1'b1, 11'h20F, 1'b1, 11'h060, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1));
      apply(mk(1'b1, 11'h210, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(mk(1'b1, 11'h060, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      idle(2);

      // Reset in the middle of a continuous read stream.
      for (int i = 0; i < 3; i++) apply(mk(1'b1, 11'(11'h300 + i), 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      #1 reset = 1'b1;
      #1 check_all_zero("async_rst");
      sbq.delete();
      last_data = '0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all_zero("held_rst");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) apply(mk(1'b1, 11'(11'h123 + i), 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      idle(3);

      if (sbq.size() != 0) chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
